branch_predictor_table: RTL

Direct-mapped branch target predictor for the fetch stage, and the consumer of the branch unit's `br_results` stream. Fetch looks up the table with the current PC and gets a registered prediction one cycle later: hit, taken, target, and call/return flags. Each resolved branch or jump in `br_results` trains the table with 2-bit saturating counters. After reset, a sequencer invalidates every entry before the table accepts lookups or updates.

---
 rtl/branch_predictor_table_pkg.sv | 48 ++++
 rtl/branch_predictor_table_counter_update.sv | 33 +++
 rtl/branch_predictor_table.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_table_pkg.sv
// Shared types, constants and PC field extraction for the branch target predictor.
package bp_types;

    localparam int BP_TAG_BITS = 8;
    localparam int BP_ID_BITS  = 4;

    localparam logic [1:0] BP_CTR_WEAK_TAKEN   = 2'b10;
    localparam logic [1:0] BP_CTR_STRONG_TAKEN = 2'b11;

    typedef enum logic {
        BP_ST_INIT,
        BP_ST_READY
    } bp_state_e;

    // target holds pc[31:1]; instructions are at least halfword aligned
    typedef struct packed {
        logic                   valid;
        logic [BP_TAG_BITS-1:0] tag;
        logic [30:0]            target;
        logic [1:0]             ctr;
        logic                   is_return;
        logic                   is_call;
    } bp_entry_t;

    typedef struct packed {
        logic                  valid;
        logic [31:0]           pc;
        logic [31:0]           target_pc;
        logic                  branch_taken;
        logic                  is_branch;
        logic                  is_return;
        logic                  is_call;
        logic [BP_ID_BITS-1:0] id;
    } br_results_t;

    function automatic logic [31:0] bp_index(input logic [31:0] pc, input int idx_bits);
        return (pc >> 2) & ((32'd1 << idx_bits) - 32'd1);
    endfunction

    function automatic logic [BP_TAG_BITS-1:0] bp_tag(input logic [31:0] pc,
                                                      input int idx_bits,
                                                      input int tag_bits);
        logic [31:0] t;
        t = (pc >> (idx_bits + 2)) & ((32'd1 << tag_bits) - 32'd1);
        return BP_TAG_BITS'(t);
    endfunction

endpackage

// File: rtl/branch_predictor_table_counter_update.sv
// Next-counter and write-enable decision for one resolved branch.
module bp_counter_update
    import bp_types::*;
(
    input  logic       hit,
    input  logic       branch_taken,
    input  logic       is_branch,
    input  logic [1:0] ctr_cur,
    output logic [1:0] ctr_next,
    output logic       write_en,
    output logic       rewrite_en
);

    logic alloc;

    always_comb begin
        alloc      = ~hit & branch_taken;
        write_en   = hit | branch_taken;
        rewrite_en = branch_taken;
        ctr_next   = ctr_cur;
        if (alloc) begin
            // unconditional jumps start fully confident
            ctr_next = is_branch ? BP_CTR_WEAK_TAKEN : BP_CTR_STRONG_TAKEN;
        end else if (hit) begin
            if (branch_taken) begin
                ctr_next = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01;
            end else begin
                ctr_next = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01;
            end
        end
    end

endmodule

// File: rtl/branch_predictor_table.sv
// Direct-mapped branch target table: registered fetch lookup, training from br_results.
//   state    | meaning
//   INIT     | sweeping indices 0..ENTRIES-1 clearing entries; lookups/updates ignored
//   READY    | normal lookup and training
module branch_predictor_table
    import bp_types::*;
#(
    parameter int ENTRIES  = 512,
    parameter int TAG_BITS = BP_TAG_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    input  logic        fetch_flush,
    input  br_results_t br_results,
    output logic        init_done,
    output logic        pred_valid,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        pred_is_return,
    output logic        pred_is_call
);

    localparam int IDX = $clog2(ENTRIES);

    bp_state_e          state_q, state_d;
    logic [IDX-1:0]     init_cnt_q, init_cnt_d;
    logic               in_init;

    bp_entry_t          table_q [ENTRIES];
    logic               wr_en;
    logic [IDX-1:0]     wr_idx;
    bp_entry_t          wr_entry;

    logic [IDX-1:0]         fetch_idx, upd_idx;
    logic [BP_TAG_BITS-1:0] fetch_tag, upd_tag;
    bp_entry_t              rd_entry, upd_entry;
    logic                   rd_hit, upd_hit;
    logic [1:0]             cu_ctr_next;
    logic                   cu_write_en, cu_rewrite_en;

    logic        pred_valid_q, pred_valid_d;
    logic        pred_hit_q, pred_hit_d;
    logic        pred_taken_q, pred_taken_d;
    logic [31:0] pred_target_q, pred_target_d;
    logic        pred_is_return_q, pred_is_return_d;
    logic        pred_is_call_q, pred_is_call_d;

    logic        unused_br;
    assign unused_br = ^{br_results.id, br_results.target_pc[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BP_ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            BP_ST_INIT: begin
                if (init_cnt_q == IDX'(ENTRIES - 1)) state_d = BP_ST_READY;
                else                                 init_cnt_d = init_cnt_q + IDX'(1);
            end
            BP_ST_READY: state_d = BP_ST_READY;
            default:     state_d = BP_ST_INIT;
        endcase
    end

    always_comb begin
        in_init   = (state_q == BP_ST_INIT);
        init_done = (state_q == BP_ST_READY);
    end

    always_comb begin
        fetch_idx = IDX'(bp_index(fetch_pc, IDX));
        fetch_tag = bp_tag(fetch_pc, IDX, TAG_BITS);
        upd_idx   = IDX'(bp_index(br_results.pc, IDX));
        upd_tag   = bp_tag(br_results.pc, IDX, TAG_BITS);
        rd_entry  = table_q[fetch_idx];
        upd_entry = table_q[upd_idx];
        rd_hit    = rd_entry.valid && (rd_entry.tag == fetch_tag);
        upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);
    end

    bp_counter_update u_counter_update (
        .hit          (upd_hit),
        .branch_taken (br_results.branch_taken),
        .is_branch    (br_results.is_branch),
        .ctr_cur      (upd_entry.ctr),
        .ctr_next     (cu_ctr_next),
        .write_en     (cu_write_en),
        .rewrite_en   (cu_rewrite_en)
    );

    // Single write port shared by the init sweep and training.
    always_comb begin
        wr_en        = 1'b0;
        wr_idx       = upd_idx;
        wr_entry     = upd_entry;
        wr_entry.ctr = cu_ctr_next;
        if (cu_rewrite_en) begin
            wr_entry.valid     = 1'b1;
            wr_entry.tag       = upd_tag;
            wr_entry.target    = br_results.target_pc[31:1];
            wr_entry.is_return = br_results.is_return;
            wr_entry.is_call   = br_results.is_call;
        end
        if (in_init) begin
            wr_en    = 1'b1;
            wr_idx   = init_cnt_q;
            wr_entry = '0;
        end else if (br_results.valid && cu_write_en) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) table_q[wr_idx] <= wr_entry;
    end

    always_comb begin
        pred_valid_d     = fetch_req & ~fetch_flush & init_done;
        pred_hit_d       = pred_hit_q;
        pred_taken_d     = pred_taken_q;
        pred_target_d    = pred_target_q;
        pred_is_return_d = pred_is_return_q;
        pred_is_call_d   = pred_is_call_q;
        if (pred_valid_d) begin
            pred_hit_d       = rd_hit;
            pred_taken_d     = rd_hit & rd_entry.ctr[1];
            pred_target_d    = {rd_entry.target, 1'b0};
            pred_is_return_d = rd_hit & rd_entry.is_return;
            pred_is_call_d   = rd_hit & rd_entry.is_call;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_q     <= 1'b0;
            pred_hit_q       <= 1'b0;
            pred_taken_q     <= 1'b0;
            pred_target_q    <= '0;
            pred_is_return_q <= 1'b0;
            pred_is_call_q   <= 1'b0;
        end else begin
            pred_valid_q     <= pred_valid_d;
            pred_hit_q       <= pred_hit_d;
            pred_taken_q     <= pred_taken_d;
            pred_target_q    <= pred_target_d;
            pred_is_return_q <= pred_is_return_d;
            pred_is_call_q   <= pred_is_call_d;
        end
    end

    assign pred_valid     = pred_valid_q;
    assign pred_hit       = pred_hit_q;
    assign pred_taken     = pred_taken_q;
    assign pred_target    = pred_target_q;
    assign pred_is_return = pred_is_return_q;
    assign pred_is_call   = pred_is_call_q;

endmodule
